// File: rtl/mux4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_pkg
// Description : Shared types and helpers for the 4-channel select sequencer
//               and the round-robin pick logic that feeds it.
//               - state_t  : sequencer states IDLE / GRANT / GAP
//               - NCH      : number of channels (4)
//               - SELW     : width of the mux select (2)
//               - onehot2  : select index -> one-hot grant vector
// Revision    : 1.0  initial release
// ============================================================================
package mux4_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Expand a select index into the matching one-hot grant vector.
    function automatic logic [NCH-1:0] onehot2(input logic [SELW-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage : mux4_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin picker for four requesters.
//               Searches upward from ptr+1 (modulo 4, wrapping 3 -> 0) and
//               returns the first requesting channel, so the channel at ptr
//               itself is considered last.
// Ports       : req   in  [3:0]  per-channel request
//               ptr   in  [1:0]  last served channel
//               found out        at least one request present
//               idx   out [1:0]  winning channel (holds ptr when none found)
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    // Candidate channels in priority order: ptr+1, ptr+2, ptr+3, ptr+4(=ptr).
    // The 2-bit addition wraps naturally, giving the modulo-4 search.
    logic [SELW-1:0] w_cand [NCH];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_cand
            assign w_cand[g] = ptr + SELW'(g + 1);
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[w_cand[i]]) begin
                found = 1'b1;
                idx   = w_cand[i];
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_sel
// Description : Round-robin select sequencer for a downstream 4:1 data mux.
//               Grants one requester at a time, holds the 2-bit select stable
//               for the whole grant, ends the grant on done, on request
//               withdrawal or on a MAX_HOLD timeout, then inserts a one-cycle
//               dead gap so the mux output settles before sel can change.
// Parameters  : MAX_HOLD  max grant length in cycles, 0 = unlimited (0..255)
// Ports       : clk        in        rising-edge clock
//               rst_n      in        asynchronous active-low reset
//               req        in  [3:0] per-channel request
//               done       in        holder finished (looked at in GRANT only)
//               sel        out [1:0] registered mux select
//               gnt        out [3:0] registered one-hot grant
//               gnt_valid  out       high exactly while in GRANT
//               timeout    out       one-cycle pulse on forced release
// Revision    : 1.0  initial release
// ============================================================================
module mux4_rr_sel
    import mux4_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    input  logic            done,
    output logic [SELW-1:0] sel,
    output logic [NCH-1:0]  gnt,
    output logic            gnt_valid,
    output logic            timeout
);

    // Counter value seen during the last permitted grant cycle. The first
    // grant cycle sees 0, so a limit of H ends the grant after H cycles.
    localparam logic       c_HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] c_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam logic [7:0] c_CNT_MAX   = 8'hFF;

    state_t          state_q,     state_d;
    logic [SELW-1:0] ptr_q,       ptr_d;
    logic [7:0]      cnt_q,       cnt_d;
    logic [SELW-1:0] sel_q,       sel_d;
    logic [NCH-1:0]  gnt_q,       gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q,   timeout_d;

    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic            w_req_held;
    logic            w_limit;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (w_found),
        .idx   (w_idx)
    );

    // Holder still requesting; sel_q is the granted channel during GRANT.
    assign w_req_held = req[sel_q];
    assign w_limit    = c_HOLD_EN && (cnt_q == c_HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (w_found) begin
                    state_d     = GRANT;
                    sel_d       = w_idx;
                    ptr_d       = w_idx;
                    gnt_d       = onehot2(w_idx);
                    gnt_valid_d = 1'b1;
                    cnt_d       = 8'd0;
                end
            end

            GRANT: begin
                // Saturate so an unlimited grant never wraps the counter.
                if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (done || !w_req_held || w_limit) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    // Only a release caused solely by the limit is a timeout;
                    // done or a withdrawn request in the same cycle wins.
                    timeout_d   = w_limit && !done && w_req_held;
                end
            end

            GAP: begin
                // sel deliberately kept so the mux input does not change yet.
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // ptr resets to 3 so channel 0 is the first to win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd3;
            cnt_q       <= 8'd0;
            sel_q       <= 2'd0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : mux4_rr_sel
`default_nettype wire

// File: doc/mux4_rr_sel.md
# mux4_rr_sel

Four-channel round-robin select sequencer sitting directly upstream of the 4:1 data multiplexer. Arbitrates among four requesting sources and drives the multiplexer's 2-bit select, holding it stable for the whole grant. A grant ends on explicit completion, when the requester drops, or on a hold timeout. A one-cycle dead gap after every grant lets the downstream mux output settle before the select changes.

## Interface
- MAX_HOLD, 16: maximum cycles a single grant may last before forced release; 0 means unlimited; legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request; bit k requests channel k (maps to mux input ik).
- done  input  1  current grant holder finished; sampled only in GRANT.
- sel  output  2  mux select (s); registered; stable throughout GRANT and GAP.
- gnt  output  4  one-hot grant, registered; all zero outside GRANT.
- gnt_valid  output  1  high exactly while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if req is nonzero, select the first set bit searching upward from ptr+1 modulo 4, wrapping 3 to 0. Load sel and gnt, set ptr to the winner, clear hold counter, go to GRANT. If req is zero, stay in IDLE.
- GRANT: gnt_valid=1, gnt=onehot(sel). Hold counter increments each cycle.
- Release conditions in GRANT, evaluated each cycle, any one exits to GAP:
  - done=1.
  - req[sel]=0 (requester withdrew).
  - MAX_HOLD≠0 and counter reaches MAX_HOLD-1.
- timeout pulses only on the MAX_HOLD exit when done=0 and req[sel]=1. If done and the limit coincide, the exit is a normal release with no pulse.
- GAP: gnt=0, gnt_valid=0, sel keeps its last value. Unconditionally go to IDLE next cycle.
- Fairness: ptr is the last granted channel, so a channel just served has lowest priority next round. With all four requesting continuously, grant order is 0,1,2,3,0,…
- Requests changing during GRANT or GAP do not affect the current grant. They are re-evaluated in IDLE only.
- Hold counter width is 8 bits. It saturates and does not wrap when MAX_HOLD=0.

## Timing
- Reset values: sel=2'b00, gnt=4'b0000, gnt_valid=0, timeout=0, state=IDLE, ptr=3 (so channel 0 wins first), counter=0.
- Reset is asynchronous. Asserting rst_n low mid-GRANT clears all outputs immediately, without waiting for a clock edge. Release of rst_n is synchronous to clk.
- Grant latency: req sampled in IDLE at edge N gives gnt, gnt_valid and sel valid after edge N; 1 cycle.
- Release: done seen at edge M gives gnt_valid=0 after M. GAP occupies cycle M+1 and IDLE evaluates at M+2. Earliest next grant is valid after edge M+2, a minimum of 2 cycles between grants.
- Grant length with MAX_HOLD=H≥1 is exactly H cycles if not released earlier. With H=1, every grant lasts 1 cycle and times out if still requested.
- timeout is asserted during the first GAP cycle only.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package mux4_pkg holds:
  - state enum {IDLE, GRANT, GAP}.
  - constant NCH=4 and select width SELW=2.
  - function onehot2(sel) returning the 4-bit one-hot code.
- One combinational sub-module, rr_pick4: inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. It is reused by later arbiters in the design.
- The top level contains the FSM, hold counter, ptr and output registers; the mux itself is instantiated by the parent, not here.

## Test plan
- Reset with req=4'b1111, then release rst_n and pulse done every 3rd grant cycle → sel sequence 0,1,2,3,0, with gnt one-hot matching sel and a 2-cycle gap between grants.
- req=4'b0100 only → sel=2 and gnt=4'b0100 one cycle after the request; drop req[2] → gnt_valid=0 next cycle, no timeout pulse.
- MAX_HOLD=4, req=4'b0001 held, done=0 → gnt_valid high exactly 4 cycles, then timeout=1 for one cycle, then re-grant to channel 0 after the gap.
- done and the MAX_HOLD limit in the same cycle → release with timeout staying 0.
- Assert rst_n low asynchronously mid-GRANT with sel=3 → sel=0, gnt=0, gnt_valid=0 before the next clk edge; after release with req=4'b1000 → channel 3 is granted.
- After grant to channel 1, req=4'b0011 → next grant is channel 0 (wrap past 3), not channel 1.
